// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx
//   Pulls bytes from a show-ahead-less upstream FIFO and sends each one as an
//   asynchronous serial frame: start bit (0), WIDTH data bits LSB first,
//   optional even-parity bit, stop bit (1). Every bit lasts
//   SYMBOL_EDGE_TIME = CLOCK_FREQ / BAUD_RATE clock cycles.
//
// Optional feature:
//   UART_TX_PARITY_EN  when defined, an even-parity bit (XOR of the data bits)
//                      is inserted between the last data bit and the stop bit,
//                      making the frame WIDTH+3 bits instead of WIDTH+2.
//
// Ports:
//   clk         system clock, rising edge
//   rst         asynchronous, active-low reset
//   fifo_dout   byte from the upstream FIFO, valid the cycle after a pop
//   fifo_empty  upstream FIFO holds no data
//   fifo_rd_en  one-cycle pop request to the FIFO
//   serial_out  UART TX line, idle high, driven straight from a flop
//   busy        high whenever the FSM is not in IDLE
//   dbg_state   current FSM state (IDLE=0, POP=1, LOAD=2, SHIFT=3)
//
// FIFO handshake: "!fifo_empty" acts as valid and a one-cycle fifo_rd_en
// pulse acts as the consuming ready. A pop is issued only from IDLE when
// fifo_empty is low; the popped byte is taken from fifo_dout exactly one
// cycle later (LOAD). Neither FIFO input is looked at while a frame shifts.
module fifo_uart_tx #(
  parameter int CLOCK_FREQ = 125_000_000,
  parameter int BAUD_RATE  = 115_200,
  parameter int WIDTH      = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] fifo_dout,
  input  logic             fifo_empty,
  output logic             fifo_rd_en,
  output logic             serial_out,
  output logic             busy,
  output logic [1:0]       dbg_state
);

  localparam int SYMBOL_EDGE_TIME = CLOCK_FREQ / BAUD_RATE;

`ifdef UART_TX_PARITY_EN
  localparam int FRAME_BITS = WIDTH + 3;
`else
  localparam int FRAME_BITS = WIDTH + 2;
`endif

  // The start bit is driven directly in LOAD, so the shift register only
  // holds what follows it: data, optional parity, stop.
  localparam int SR_W  = FRAME_BITS - 1;
  localparam int CYC_W = (SYMBOL_EDGE_TIME > 1) ? $clog2(SYMBOL_EDGE_TIME) : 1;
  localparam int BIT_W = $clog2(FRAME_BITS);

  localparam logic [CYC_W-1:0] CYC_LAST = CYC_W'(SYMBOL_EDGE_TIME - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(FRAME_BITS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    POP   = 2'd1,
    LOAD  = 2'd2,
    SHIFT = 2'd3
  } state_t;

  state_t            state;
  logic [CYC_W-1:0]  cycle_cnt;
  logic [BIT_W-1:0]  bit_cnt;
  logic [SR_W-1:0]   shift_reg;
  logic [SR_W-1:0]   payload;

  // Everything after the start bit, LSB transmitted first.
  always_comb begin
    payload = '0;
`ifdef UART_TX_PARITY_EN
    payload = {1'b1, ^fifo_dout, fifo_dout};
`else
    payload = {1'b1, fifo_dout};
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      serial_out <= 1'b1;
      fifo_rd_en <= 1'b0;
      busy       <= 1'b0;
      cycle_cnt  <= '0;
      bit_cnt    <= '0;
      shift_reg  <= '0;
    end else begin
      case (state)
        IDLE: begin
          serial_out <= 1'b1;
          fifo_rd_en <= 1'b0;
          cycle_cnt  <= '0;
          bit_cnt    <= '0;
          if (!fifo_empty) begin
            // Outputs are registered, so assert them on the way into POP.
            state      <= POP;
            fifo_rd_en <= 1'b1;
            busy       <= 1'b1;
          end
        end

        POP: begin
          fifo_rd_en <= 1'b0;
          state      <= LOAD;
        end

        LOAD: begin
          // fifo_dout is valid now, one cycle after the pop.
          shift_reg  <= payload;
          serial_out <= 1'b0;
          cycle_cnt  <= '0;
          bit_cnt    <= '0;
          state      <= SHIFT;
        end

        SHIFT: begin
          if (cycle_cnt == CYC_LAST) begin
            cycle_cnt <= '0;
            if (bit_cnt == BIT_LAST) begin
              // Stop bit done: line already high, drop back to IDLE.
              bit_cnt    <= '0;
              serial_out <= 1'b1;
              busy       <= 1'b0;
              shift_reg  <= '0;
              state      <= IDLE;
            end else begin
              bit_cnt    <= bit_cnt + BIT_W'(1);
              serial_out <= shift_reg[0];
              shift_reg  <= shift_reg >> 1;
            end
          end else begin
            cycle_cnt <= cycle_cnt + CYC_W'(1);
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign dbg_state = state;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Bench for fifo_uart_tx at 1 MHz / 100 kbaud (10 cycles per bit).
// Stimulus tasks push expected pop cycles, start cycles, busy-fall cycles and
// frame bit patterns into queues; independent monitors pop and compare.
module tb_fifo_uart_tx;

  localparam int CLOCK_FREQ = 1_000_000;
  localparam int BAUD_RATE  = 100_000;
  localparam int SET        = 10;
`ifdef UART_TX_PARITY_EN
  localparam int FB = 11;
`else
  localparam int FB = 10;
`endif
  localparam int FRAME_CYC = FB * SET;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] fifo_dout;
  logic       fifo_empty;
  logic       fifo_rd_en;
  logic       serial_out;
  logic       busy;
  logic [1:0] dbg_state;

  int cyc = 0;
  int chk_cnt = 0;
  int pass_cnt = 0;

  logic [7:0]    fifo_q[$];
  logic [FB-1:0] exp_q[$];
  int            exp_rd_q[$];
  int            exp_start_q[$];
  int            exp_idle_q[$];
  logic          fifo_override = 1'b0;

  fifo_uart_tx #(
    .CLOCK_FREQ(CLOCK_FREQ),
    .BAUD_RATE (BAUD_RATE),
    .WIDTH     (8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .fifo_dout (fifo_dout),
    .fifo_empty(fifo_empty),
    .fifo_rd_en(fifo_rd_en),
    .serial_out(serial_out),
    .busy      (busy),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / cycle count ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard helpers ----------------
  task automatic check(input string name, input int act, input int exp_v);
    chk_cnt++;
    if (act == exp_v) pass_cnt++;
    else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp_v, cyc);
  endtask

  // Line sequence LSB first: start, data, [parity], stop.
  function automatic logic [FB-1:0] frame_of(input logic [7:0] d);
`ifdef UART_TX_PARITY_EN
    return {1'b1, ^d, d, 1'b0};
`else
    return {1'b1, d, 1'b0};
`endif
  endfunction

  // ---------------- upstream FIFO model ----------------
  initial begin : fifo_model
    logic rd;
    forever begin
      @(posedge clk);
      rd = fifo_rd_en;
      #1;
      if (rd && fifo_q.size() > 0) fifo_dout = fifo_q.pop_front();
      if (!fifo_override) fifo_empty = (fifo_q.size() == 0);
    end
  end

  // ---------------- driver tasks ----------------
  // Loads one byte; fifo_empty falls in cycle n.
  task automatic send_one(input logic [7:0] d, input bit expect_idle);
    int n;
    @(posedge clk);
    #2;
    n = cyc;
    fifo_q.push_back(d);
    exp_q.push_back(frame_of(d));
    exp_rd_q.push_back(n + 1);
    exp_start_q.push_back(n + 3);
    if (expect_idle) exp_idle_q.push_back(n + 3 + FRAME_CYC);
    fifo_empty = 1'b0;
  endtask

  // Two bytes preloaded: second pop one idle cycle after the first frame.
  task automatic send_two(input logic [7:0] d0, input logic [7:0] d1);
    int n;
    @(posedge clk);
    #2;
    n = cyc;
    fifo_q.push_back(d0);
    fifo_q.push_back(d1);
    exp_q.push_back(frame_of(d0));
    exp_q.push_back(frame_of(d1));
    exp_rd_q.push_back(n + 1);
    exp_rd_q.push_back(n + FRAME_CYC + 4);
    exp_start_q.push_back(n + 3);
    exp_start_q.push_back(n + FRAME_CYC + 6);
    exp_idle_q.push_back(n + 3 + FRAME_CYC);
    exp_idle_q.push_back(n + 2 * FRAME_CYC + 6);
    fifo_empty = 1'b0;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
  endtask

  // ---------------- monitors ----------------
  initial begin : pop_mon
    forever begin
      @(negedge clk);
      if (rst && fifo_rd_en) begin
        if (exp_rd_q.size() == 0) check("unexpected fifo_rd_en pulse", cyc, -1);
        else check("fifo_rd_en cycle", cyc, exp_rd_q.pop_front());
      end
    end
  end

  initial begin : busy_mon
    logic prev;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if (rst && prev && !busy) begin
        if (exp_idle_q.size() == 0) check("unexpected busy fall", cyc, -1);
        else check("busy fall cycle", cyc, exp_idle_q.pop_front());
      end
      prev = busy;
    end
  end

  initial begin : frame_mon
    logic [FB-1:0] exp_f;
    logic [FB-1:0] rx_f;
    int            width_err;
    bit            aborted;
    bit            have_exp;
    forever begin
      @(negedge clk);
      if (rst && serial_out == 1'b0) begin
        if (exp_start_q.size() == 0) check("unexpected start bit", cyc, -1);
        else check("start bit cycle", cyc, exp_start_q.pop_front());
        have_exp = (exp_q.size() > 0);
        exp_f = '0;
        if (have_exp) exp_f = exp_q.pop_front();
        rx_f = '0;
        width_err = 0;
        aborted = 1'b0;
        for (int k = 0; k < FB && !aborted; k++) begin
          for (int j = 0; j < SET && !aborted; j++) begin
            if (k != 0 || j != 0) begin
              @(negedge clk);
              if (!rst) aborted = 1'b1;
            end
            if (!aborted) begin
              if (j == 0) rx_f[k] = serial_out;
              else if (serial_out != rx_f[k]) width_err++;
            end
          end
        end
        if (!aborted) begin
          if (have_exp) check("frame bits", int'(rx_f), int'(exp_f));
          else check("unexpected frame", int'(rx_f), -1);
          check("bit width", width_err, 0);
        end
      end
    end
  end

  // ---------------- main sequence ----------------
  initial begin : main
    int bad_ser;
    int bad_busy;
    int bad_rd;
    rst = 1'b1;
    fifo_empty = 1'b1;
    fifo_dout = 8'h00;
    #1 rst = 1'b0;

    // reset hold and quiet idle
    wait_cycles(5);
    #2;
    check("reset serial_out", int'(serial_out), 1);
    check("reset busy", int'(busy), 0);
    check("reset fifo_rd_en", int'(fifo_rd_en), 0);
    check("reset state", int'(dbg_state), 0);
    rst = 1'b1;
    bad_ser = 0;
    bad_busy = 0;
    bad_rd = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (serial_out !== 1'b1) bad_ser++;
      if (busy !== 1'b0) bad_busy++;
      if (fifo_rd_en !== 1'b0) bad_rd++;
    end
    check("idle serial_out bad cycles", bad_ser, 0);
    check("idle busy bad cycles", bad_busy, 0);
    check("idle fifo_rd_en bad cycles", bad_rd, 0);

    // single byte
    send_one(8'hA5, 1'b1);
    wait_cycles(FRAME_CYC + 20);

    // back-to-back frames
    send_two(8'h00, 8'hFF);
    wait_cycles(2 * FRAME_CYC + 30);

    // reset during data bit 3 of 0x3C (frame cycle 45)
    send_one(8'h3C, 1'b0);
    wait_cycles(48);
    #3;
    rst = 1'b0;
    #1;
    check("async reset serial_out", int'(serial_out), 1);
    check("async reset busy", int'(busy), 0);
    check("async reset fifo_rd_en", int'(fifo_rd_en), 0);
    wait_cycles(3);
    #2;
    rst = 1'b1;
    wait_cycles(FRAME_CYC + 20);
    check("state after reset release", int'(dbg_state), 0);

    // FIFO activity while shifting 0x81
    send_one(8'h81, 1'b1);
    wait_cycles(5);
    #2;
    fifo_override = 1'b1;
    for (int i = 0; i < 80; i++) begin
      fifo_empty = 1'($urandom_range(0, 1));
      fifo_dout = 8'hFF;
      @(posedge clk);
      #2;
    end
    fifo_empty = 1'b1;
    fifo_override = 1'b0;
    wait_cycles(FRAME_CYC + 20);

`ifdef UART_TX_PARITY_EN
    // parity frame: 0x07 has odd weight, parity bit 1
    send_one(8'h07, 1'b1);
    wait_cycles(FRAME_CYC + 20);
`endif

    check("pending frames", exp_q.size(), 0);
    check("pending pops", exp_rd_q.size(), 0);
    check("pending starts", exp_start_q.size(), 0);
    check("pending busy falls", exp_idle_q.size(), 0);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/fifo_uart_tx.md
FIFO_UART_TX -- requirements
Module: fifo_uart_tx

Interface
REQ-001 SHALL have parameter CLOCK_FREQ, default 125_000_000, system clock frequency in Hz.
REQ-002 SHALL have parameter BAUD_RATE, default 115_200, serial line rate in bit/s.
REQ-003 SHALL have parameter WIDTH, default 8, data bits per frame.
REQ-004 SHALL have port clk, input, 1, the single clock; all logic on its rising edge.
REQ-005 SHALL have port rst, input, 1, reset; asynchronous and active-low.
REQ-006 SHALL have port fifo_dout, input, WIDTH, byte from the upstream FIFO; valid the cycle after a pop.
REQ-007 SHALL have port fifo_empty, input, 1, upstream FIFO holds no data.
REQ-008 SHALL have port fifo_rd_en, output, 1, single-cycle pop request to the FIFO.
REQ-009 SHALL have port serial_out, output, 1, UART TX line; idle high.
REQ-010 SHALL have port busy, output, 1, high in any state other than IDLE.

Function
REQ-011 SHALL define SYMBOL_EDGE_TIME = CLOCK_FREQ / BAUD_RATE (integer divide), in clock cycles per bit.
REQ-012 SHALL implement the FSM states IDLE, POP, LOAD and SHIFT.
REQ-013 IDLE: serial_out=1 and fifo_rd_en=0; if fifo_empty=0, go to POP on the next edge.
REQ-014 POP: fifo_rd_en=1 for exactly this one cycle, then go to LOAD.
REQ-015 LOAD: capture fifo_dout into the frame shift register at the end of the cycle, then go to SHIFT.
REQ-016 SHIFT: send the start bit (0), then WIDTH data bits LSB first, then the stop bit (1); each bit holds for exactly SYMBOL_EDGE_TIME cycles.
REQ-017 serial_out SHALL be driven from a register, with no combinational glitches.
REQ-018 Latency: if fifo_empty falls to 0 while in IDLE in cycle N, fifo_rd_en SHALL be high in cycle N+1 and the start bit SHALL begin in cycle N+3.
REQ-019 When the stop bit ends, go to IDLE; if the FIFO is still non-empty, the next POP SHALL follow with exactly one idle-high cycle between frames.
REQ-020 fifo_rd_en SHALL never be asserted outside POP; exactly one pop per frame.
REQ-021 fifo_empty and fifo_dout SHALL be ignored in SHIFT, so FIFO activity mid-frame does not corrupt the frame.
REQ-022 The bit counter and the cycle counter SHALL each be sized with $clog2 and wrap to 0 at every bit boundary without overflow.

Reset
REQ-023 While rst=0, the block SHALL hold state=IDLE, serial_out=1, fifo_rd_en=0, busy=0, and both counters and the shift register at 0.
REQ-024 Assertion of rst mid-frame SHALL return serial_out to 1 immediately (asynchronously); the partial frame is abandoned and not retransmitted.
REQ-025 After rst is released, the block SHALL resume from IDLE on the first rising edge.

Configuration
REQ-026 Macro UART_TX_PARITY_EN, when defined, SHALL insert an even-parity bit (XOR of the data bits) between the last data bit and the stop bit, giving a WIDTH+3 bit frame.
REQ-027 Without UART_TX_PARITY_EN, the frame SHALL be WIDTH+2 bits with no parity logic synthesized; all other timing is identical.

Verification (CLOCK_FREQ=1_000_000, BAUD_RATE=100_000, SYMBOL_EDGE_TIME=10)
REQ-028 Reset check: hold rst=0 for 5 cycles, then release with fifo_empty=1 -> serial_out=1, busy=0 and fifo_rd_en=0 for at least 100 cycles.
REQ-029 Single byte: FIFO pre-loaded with 8'hA5 and fifo_empty falls at cycle N -> fifo_rd_en high only at N+1; serial_out from N+3 is 0,1,0,1,0,0,1,0,1,1 at 10 cycles per bit; busy falls at N+103.
REQ-030 Back-to-back: FIFO pre-loaded with 8'h00 then 8'hFF -> two frames separated by exactly 1 idle cycle plus the POP/LOAD cycles (3 high cycles total); exactly 2 fifo_rd_en pulses.
REQ-031 Reset mid-frame: assert rst during data bit 3 of 8'h3C -> serial_out=1 within the same cycle; after release with the FIFO empty, no further pulses on fifo_rd_en.
REQ-032 Parity build (UART_TX_PARITY_EN defined): send 8'h07 -> parity bit = 1, the frame is 11 bits, and busy falls 113 cycles after fifo_empty falls.
REQ-033 Mid-frame FIFO activity: toggle fifo_empty and drive fifo_dout=8'hFF during SHIFT of 8'h81 -> the transmitted bits match 8'h81 and no extra pop occurs.
